// File: rtl/ddp_join_pkg.sv
// ---------------------------------------------------------------------------
// ddp_join_pkg
//   Shared definitions for the DDP join stage matching store.
//   - TAG_W / TOKEN_W / LR_BIT : layout of an incoming token
//   - token_t                  : {tag, lr} view of the 19-bit token word
//   - fire_pkt_t               : {tag, data_l, data_r} fired packet at the
//                                default operand width
// ---------------------------------------------------------------------------
package ddp_join_pkg;

    localparam int TAG_W   = 18;
    localparam int TOKEN_W = 19;
    localparam int LR_BIT  = 0;
    localparam int DEF_DW  = 16;

    // lr is the last field so that it lands on bit 0 of the packed word.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             lr;
    } token_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DEF_DW-1:0] data_l;
        logic [DEF_DW-1:0] data_r;
    } fire_pkt_t;

endpackage

// File: rtl/join_entry_slot.sv
// ---------------------------------------------------------------------------
// join_entry_slot
//   One entry of the matching store. Holds a parked token (valid, tag, lr)
//   and its operand data, and compares itself against the token currently
//   presented at the input.
// Ports
//   clk, rst    : clock, synchronous active-high reset (clears valid only)
//   wr_en       : park the presented token in this entry
//   clr         : free this entry (its partner has arrived)
//   in_tag      : tag of the presented token
//   in_lr       : LR bit of the presented token
//   in_data     : operand data of the presented token
//   valid       : entry holds a waiting token
//   match       : waiting token has the same tag and the opposite LR
//   dup         : waiting token has the same tag and the same LR
//   data        : stored operand data
// ---------------------------------------------------------------------------
module join_entry_slot
    import ddp_join_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             clr,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_lr,
    input  logic [DW-1:0]    in_data,
    output logic             valid,
    output logic             match,
    output logic             dup,
    output logic [DW-1:0]    data
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             lr_q, lr_d;
    logic [DW-1:0]    data_q, data_d;
    logic             tag_eq;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        lr_d    = lr_q;
        data_d  = data_q;
        // The top never asserts wr_en and clr on the same entry in one cycle.
        if (clr) begin
            valid_d = 1'b0;
        end else if (wr_en) begin
            valid_d = 1'b1;
            tag_d   = in_tag;
            lr_d    = in_lr;
            data_d  = in_data;
        end
    end

    // Only the valid bit needs a reset; payload is ignored while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q  <= tag_d;
        lr_q   <= lr_d;
        data_q <= data_d;
    end

    assign tag_eq = valid_q && (tag_q == in_tag);
    assign match  = tag_eq && (lr_q != in_lr);
    assign dup    = tag_eq && (lr_q == in_lr);
    assign valid  = valid_q;
    assign data   = data_q;

endmodule

// File: rtl/join_match_ctrl.sv
// ---------------------------------------------------------------------------
// join_match_ctrl
//   Multi-entry matching-store controller for the DDP join stage. Unmatched
//   tokens are parked in the lowest free entry; when the partner (same tag,
//   opposite LR) arrives the pair is fired as one packet and the entry freed.
// Ports
//   CP, MR      : clock, synchronous active-high reset
//   IN_VALID    : input token valid
//   IN_READY    : token accepted when IN_VALID && IN_READY
//   IN_TOKEN    : [18:1] tag, [0] LR (0 = left, 1 = right)
//   IN_DATA     : operand data
//   OUT_VALID   : fired packet valid
//   OUT_READY   : downstream accepts the packet
//   OUT_TAG     : tag of the fired pair
//   OUT_DATA_L  : data of the LR=0 operand
//   OUT_DATA_R  : data of the LR=1 operand
//   OCCUPANCY   : number of waiting entries
//   FULL        : OCCUPANCY == N_ENTRY
//   DUP_ERR     : one-cycle pulse, token with same tag and LR already waiting
// ---------------------------------------------------------------------------
module join_match_ctrl
    import ddp_join_pkg::*;
#(
    parameter int N_ENTRY = 8,
    parameter int DW      = 16
) (
    input  logic                         CP,
    input  logic                         MR,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [TOKEN_W-1:0]           IN_TOKEN,
    input  logic [DW-1:0]                IN_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [TAG_W-1:0]             OUT_TAG,
    output logic [DW-1:0]                OUT_DATA_L,
    output logic [DW-1:0]                OUT_DATA_R,
    output logic [$clog2(N_ENTRY+1)-1:0] OCCUPANCY,
    output logic                         FULL,
    output logic                         DUP_ERR
);

    localparam int IDX_W = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
    localparam int OCC_W = $clog2(N_ENTRY + 1);

    token_t in_tok;
    assign in_tok = token_t'(IN_TOKEN);

    logic [N_ENTRY-1:0] slot_valid;
    logic [N_ENTRY-1:0] slot_match;
    logic [N_ENTRY-1:0] slot_dup;
    logic [N_ENTRY-1:0] slot_wr;
    logic [N_ENTRY-1:0] slot_clr;
    logic [DW-1:0]      slot_data [N_ENTRY];

    for (genvar g = 0; g < N_ENTRY; g++) begin : g_slot
        join_entry_slot #(
            .DW (DW)
        ) u_slot (
            .clk     (CP),
            .rst     (MR),
            .wr_en   (slot_wr[g]),
            .clr     (slot_clr[g]),
            .in_tag  (in_tok.tag),
            .in_lr   (in_tok.lr),
            .in_data (IN_DATA),
            .valid   (slot_valid[g]),
            .match   (slot_match[g]),
            .dup     (slot_dup[g]),
            .data    (slot_data[g])
        );
    end

    // Priority encoders: scanning downward lets the lowest index win.
    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;

    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = N_ENTRY - 1; i >= 0; i--) begin
            if (slot_match[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!slot_valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    logic [DW-1:0] hit_data;
    assign hit_data = slot_data[hit_idx];

    // Registered state
    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [DW-1:0]    out_data_l_q, out_data_l_d;
    logic [DW-1:0]    out_data_r_q, out_data_r_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             dup_err_q, dup_err_d;

    // Handshake
    logic full;
    logic out_free;
    logic in_ready;
    logic accept;
    logic fire;
    logic alloc;

    assign full     = (occ_q == OCC_W'(N_ENTRY));
    assign out_free = !out_valid_q || OUT_READY;
    // A hit frees an entry, so it must never be blocked by a full store.
    assign in_ready = !MR && out_free && (hit_any || !full);
    assign accept   = IN_VALID && in_ready;
    assign fire     = accept && hit_any;
    assign alloc    = accept && !hit_any;

    always_comb begin
        slot_wr  = '0;
        slot_clr = '0;
        if (alloc) begin
            slot_wr[free_idx] = 1'b1;
        end
        if (fire) begin
            slot_clr[hit_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q && !OUT_READY;
        out_tag_d    = out_tag_q;
        out_data_l_d = out_data_l_q;
        out_data_r_d = out_data_r_q;
        // fire implies out_free, so a held packet is never overwritten.
        if (fire) begin
            out_valid_d = 1'b1;
            out_tag_d   = in_tok.tag;
            if (in_tok.lr) begin
                out_data_l_d = hit_data;
                out_data_r_d = IN_DATA;
            end else begin
                out_data_l_d = IN_DATA;
                out_data_r_d = hit_data;
            end
        end
    end

    // Only one token is accepted per cycle, so occupancy moves by at most 1.
    always_comb begin
        occ_d     = occ_q + OCC_W'(alloc) - OCC_W'(fire);
        dup_err_d = alloc && (|slot_dup);
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            out_valid_q  <= 1'b0;
            out_tag_q    <= '0;
            out_data_l_q <= '0;
            out_data_r_q <= '0;
            occ_q        <= '0;
            dup_err_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_tag_q    <= out_tag_d;
            out_data_l_q <= out_data_l_d;
            out_data_r_q <= out_data_r_d;
            occ_q        <= occ_d;
            dup_err_q    <= dup_err_d;
        end
    end

    assign IN_READY   = in_ready;
    assign OUT_VALID  = out_valid_q;
    assign OUT_TAG    = out_tag_q;
    assign OUT_DATA_L = out_data_l_q;
    assign OUT_DATA_R = out_data_r_q;
    assign OCCUPANCY  = occ_q;
    assign FULL       = full;
    assign DUP_ERR    = dup_err_q;

endmodule

// File: tb/tb_join_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_join_match_ctrl
//   Directed stimulus for join_match_ctrl. Expected fired packets are queued
//   as tokens are sent; a negedge monitor compares every presented packet
//   against the queue head and pops it on a downstream transfer.
// ---------------------------------------------------------------------------
module tb_join_match_ctrl;

    logic        CP = 1'b0;
    logic        MR;
    logic        IN_VALID;
    logic        IN_READY;
    logic [18:0] IN_TOKEN;
    logic [15:0] IN_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [17:0] OUT_TAG;
    logic [15:0] OUT_DATA_L;
    logic [15:0] OUT_DATA_R;
    logic [3:0]  OCCUPANCY;
    logic        FULL;
    logic        DUP_ERR;

    join_match_ctrl #(.N_ENTRY(8), .DW(16)) dut (
        .CP         (CP),
        .MR         (MR),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_TOKEN   (IN_TOKEN),
        .IN_DATA    (IN_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_TAG    (OUT_TAG),
        .OUT_DATA_L (OUT_DATA_L),
        .OUT_DATA_R (OUT_DATA_R),
        .OCCUPANCY  (OCCUPANCY),
        .FULL       (FULL),
        .DUP_ERR    (DUP_ERR)
    );

    always #5 CP = ~CP;

    typedef struct packed {
        logic [17:0] tag;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Present one token, wait (bounded) for acceptance. When a fire is
    // expected, the packet is queued for the monitor.
    task automatic send(input logic [17:0] tag, input logic lr, input logic [15:0] data,
                        input logic fires, input logic [15:0] exp_l, input logic [15:0] exp_r);
        bit done = 0;
        IN_VALID = 1'b1;
        IN_TOKEN = {tag, lr};
        IN_DATA  = data;
        if (fires) exp_q.push_back('{tag: tag, l: exp_l, r: exp_r});
        for (int c = 0; c < 50 && !done; c++) begin
            #1;
            if (IN_READY) done = 1;
            @(posedge CP);
            #1;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: tag %0h lr %0d never accepted", tag, lr);
        end
        IN_VALID = 1'b0;
    endtask

    // Monitor: the head packet must be on the bus whenever OUT_VALID is high;
    // it leaves the queue only when the downstream takes it.
    always @(negedge CP) begin
        if (!MR && OUT_VALID) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pkt: got tag %0h L %0h R %0h, expected none",
                         OUT_TAG, OUT_DATA_L, OUT_DATA_R);
            end else begin
                if ({OUT_TAG, OUT_DATA_L, OUT_DATA_R} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL pkt: got tag %0h L %0h R %0h, expected tag %0h L %0h R %0h",
                             OUT_TAG, OUT_DATA_L, OUT_DATA_R,
                             exp_q[0].tag, exp_q[0].l, exp_q[0].r);
                end
                if (OUT_READY) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        MR        = 1'b1;
        IN_VALID  = 1'b0;
        IN_TOKEN  = '0;
        IN_DATA   = '0;
        OUT_READY = 1'b1;
        tick();
        tick();
        MR = 1'b0;

        // Reset state
        chk("rst_occ", 32'(OCCUPANCY), 32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_dup", 32'(DUP_ERR), 32'd0);
        chk("rst_out_tag", 32'(OUT_TAG), 32'd0);
        chk("rst_out_l", 32'(OUT_DATA_L), 32'd0);

        // Pair L then R
        send(18'h000A5, 1'b0, 16'h1111, 1'b0, 16'h0, 16'h0);
        chk("pair_occ1", 32'(OCCUPANCY), 32'd1);
        chk("pair_noout", 32'(OUT_VALID), 32'd0);
        send(18'h000A5, 1'b1, 16'h2222, 1'b1, 16'h1111, 16'h2222);
        chk("pair_valid", 32'(OUT_VALID), 32'd1);
        chk("pair_occ0", 32'(OCCUPANCY), 32'd0);
        tick();
        chk("pair_valid_fall", 32'(OUT_VALID), 32'd0);

        // Reverse order R then L
        send(18'h000B7, 1'b1, 16'h3333, 1'b0, 16'h0, 16'h0);
        send(18'h000B7, 1'b0, 16'h4444, 1'b1, 16'h4444, 16'h3333);
        chk("rev_l", 32'(OUT_DATA_L), 32'h4444);
        chk("rev_r", 32'(OUT_DATA_R), 32'h3333);
        tick();

        // Fill the store
        for (int i = 0; i < 8; i++)
            send(18'h00100 + 18'(i), 1'b0, 16'h5000 + 16'(i), 1'b0, 16'h0, 16'h0);
        chk("fill_full", 32'(FULL), 32'd1);
        chk("fill_occ", 32'(OCCUPANCY), 32'd8);
        IN_VALID = 1'b1;
        IN_TOKEN = {18'h001FF, 1'b0};
        IN_DATA  = 16'hBEEF;
        #1;
        chk("fill_miss_blocked", 32'(IN_READY), 32'd0);
        IN_TOKEN = {18'h00103, 1'b1};
        IN_DATA  = 16'hAAAA;
        #1;
        chk("fill_hit_ready", 32'(IN_READY), 32'd1);
        send(18'h00103, 1'b1, 16'hAAAA, 1'b1, 16'h5003, 16'hAAAA);
        chk("fill_occ7", 32'(OCCUPANCY), 32'd7);
        chk("fill_notfull", 32'(FULL), 32'd0);
        for (int i = 0; i < 8; i++)
            if (i != 3)
                send(18'h00100 + 18'(i), 1'b1, 16'h6000 + 16'(i), 1'b1,
                     16'h5000 + 16'(i), 16'h6000 + 16'(i));
        tick();
        chk("drain_occ", 32'(OCCUPANCY), 32'd0);

        // Back-pressure
        OUT_READY = 1'b0;
        send(18'h000C1, 1'b0, 16'h0C10, 1'b0, 16'h0, 16'h0);
        send(18'h000C2, 1'b0, 16'h0C20, 1'b0, 16'h0, 16'h0);
        send(18'h000C1, 1'b1, 16'h0C11, 1'b1, 16'h0C10, 16'h0C11);
        IN_VALID = 1'b1;
        IN_TOKEN = {18'h000C2, 1'b1};
        IN_DATA  = 16'h0C21;
        #1;
        chk("bp_ready_low", 32'(IN_READY), 32'd0);
        tick();
        tick();
        tick();
        chk("bp_hold_valid", 32'(OUT_VALID), 32'd1);
        chk("bp_hold_tag", 32'(OUT_TAG), 32'h000C1);
        chk("bp_hold_occ", 32'(OCCUPANCY), 32'd1);
        OUT_READY = 1'b1;
        send(18'h000C2, 1'b1, 16'h0C21, 1'b1, 16'h0C20, 16'h0C21);
        chk("bp_nobubble_valid", 32'(OUT_VALID), 32'd1);
        chk("bp_nobubble_tag", 32'(OUT_TAG), 32'h000C2);
        tick();
        chk("bp_done", 32'(OUT_VALID), 32'd0);

        // Duplicate
        send(18'h00001, 1'b0, 16'hD001, 1'b0, 16'h0, 16'h0);
        chk("dup_first_none", 32'(DUP_ERR), 32'd0);
        send(18'h00001, 1'b0, 16'hD002, 1'b0, 16'h0, 16'h0);
        chk("dup_pulse", 32'(DUP_ERR), 32'd1);
        chk("dup_occ2", 32'(OCCUPANCY), 32'd2);
        tick();
        chk("dup_pulse_end", 32'(DUP_ERR), 32'd0);
        send(18'h00001, 1'b1, 16'hE000, 1'b1, 16'hD001, 16'hE000);
        chk("dup_fire_l", 32'(OUT_DATA_L), 32'hD001);
        send(18'h00001, 1'b1, 16'hE001, 1'b1, 16'hD002, 16'hE001);
        tick();
        chk("dup_occ0", 32'(OCCUPANCY), 32'd0);

        // Reset mid-run
        OUT_READY = 1'b0;
        for (int i = 1; i <= 4; i++)
            send(18'h00200 + 18'(i), 1'b0, 16'h7000 + 16'(i), 1'b0, 16'h0, 16'h0);
        send(18'h00205, 1'b0, 16'h7005, 1'b0, 16'h0, 16'h0);
        send(18'h00205, 1'b1, 16'h8005, 1'b1, 16'h7005, 16'h8005);
        chk("mr_pre_occ", 32'(OCCUPANCY), 32'd4);
        chk("mr_pre_valid", 32'(OUT_VALID), 32'd1);
        MR       = 1'b1;
        IN_VALID = 1'b1;
        IN_TOKEN = {18'h00201, 1'b1};
        IN_DATA  = 16'h9999;
        #1;
        chk("mr_ready_low", 32'(IN_READY), 32'd0);
        tick();
        MR       = 1'b0;
        IN_VALID = 1'b0;
        exp_q.delete();
        chk("mr_occ0", 32'(OCCUPANCY), 32'd0);
        chk("mr_valid0", 32'(OUT_VALID), 32'd0);
        OUT_READY = 1'b1;
        send(18'h00201, 1'b1, 16'h7777, 1'b0, 16'h0, 16'h0);
        chk("mr_alloc_occ", 32'(OCCUPANCY), 32'd1);
        chk("mr_alloc_nofire", 32'(OUT_VALID), 32'd0);
        tick();
        chk("mr_alloc_nofire2", 32'(OUT_VALID), 32'd0);
        send(18'h00201, 1'b0, 16'h1234, 1'b1, 16'h1234, 16'h7777);
        tick();
        tick();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
